// File: rtl/iir_multi_if.sv
// rtl/iir_multi_if.sv - sample-in / filtered-out handshake bundle for iir_multi
interface iir_multi_if #(
  parameter int width_p     = 10,
  parameter int coef_frac_p = 5,
  parameter int channels_p  = 4
);
  localparam int chan_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1;

  logic                        valid_i;
  logic signed [width_p-1:0]   data_i;
  logic [chan_w_lp-1:0]        chan_i;
  logic [coef_frac_p:0]        coef_i;
  logic                        clear_i;
  logic                        ready_o;
  logic                        valid_o;
  logic signed [width_p-1:0]   data_o;
  logic [chan_w_lp-1:0]        chan_o;
  logic                        ready_i;

  modport slave (
    input  valid_i, data_i, chan_i, coef_i, clear_i, ready_i,
    output ready_o, valid_o, data_o, chan_o
  );

  modport master (
    output valid_i, data_i, chan_i, coef_i, clear_i, ready_i,
    input  ready_o, valid_o, data_o, chan_o
  );
endinterface

// File: rtl/iir_multi.sv
// rtl/iir_multi.sv - multi-channel first-order IIR low-pass; IIR_MULTI_ROUND_EN selects rounded saturating output
module iir_multi #(
  parameter int width_p     = 10,
  parameter int frac_p      = 22,
  parameter int coef_frac_p = 5,
  parameter int channels_p  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  iir_multi_if.slave io
);
  localparam int wf_lp     = width_p + frac_p;
  localparam int pw_lp     = wf_lp + coef_frac_p + 3;
  localparam int chan_w_lp = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam logic [coef_frac_p:0] one_lp = {1'b1, {coef_frac_p{1'b0}}};

  logic signed [wf_lp-1:0] state_q [channels_p];

  logic                      accept;
  logic                      chan_ok;
  logic                      load;
  logic signed [wf_lp-1:0]   x;
  logic signed [wf_lp-1:0]   s;
  logic [coef_frac_p:0]      bc;
  logic signed [wf_lp:0]     d;
  logic signed [pw_lp-1:0]   d_ext;
  logic signed [pw_lp-1:0]   bc_ext;
  logic signed [pw_lp-1:0]   prod;
  logic signed [wf_lp-1:0]   p;
  logic signed [wf_lp-1:0]   acc;
  logic signed [width_p-1:0] y;

  assign io.ready_o = ~io.valid_o | io.ready_i;
  assign accept     = io.valid_i & io.ready_o;
  assign chan_ok    = int'(io.chan_i) < channels_p;
  assign load       = accept & chan_ok;

  // Filter datapath: a coincident clear makes this sample start from zero state
  always_comb begin
    s = '0;
    if (!io.clear_i && chan_ok) s = state_q[io.chan_i];
    x      = {io.data_i, {frac_p{1'b0}}};
    bc     = (io.coef_i > one_lp) ? one_lp : io.coef_i;
    d      = {x[wf_lp-1], x} - {s[wf_lp-1], s};
    d_ext  = {{(pw_lp-wf_lp-1){d[wf_lp]}}, d};
    bc_ext = {{(pw_lp-coef_frac_p-1){1'b0}}, bc};
    prod   = d_ext * bc_ext;
    p      = wf_lp'(prod >>> coef_frac_p);
    acc    = s + p;
  end

`ifdef IIR_MULTI_ROUND_EN
  logic [width_p:0] rnd_hi;

  // Round half up on the integer part; only positive overflow is possible
  always_comb begin
    rnd_hi = (width_p+1)'(({acc[wf_lp-1], acc} +
             {{(width_p+1){1'b0}}, 1'b1, {(frac_p-1){1'b0}}}) >> frac_p);
    if (rnd_hi[width_p:width_p-1] == 2'b01) y = {1'b0, {(width_p-1){1'b1}}};
    else                                    y = rnd_hi[width_p-1:0];
  end
`else
  // Floor the state to its integer part
  always_comb begin
    y = acc[wf_lp-1:frac_p];
  end
`endif

  // Single-entry elastic output register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      io.valid_o <= 1'b0;
      io.data_o  <= '0;
      io.chan_o  <= '0;
    end else if (load) begin
      io.valid_o <= 1'b1;
      io.data_o  <= y;
      io.chan_o  <= io.chan_i;
    end else if (io.ready_i) begin
      io.valid_o <= 1'b0;
    end
  end

  // Per-channel state: accepted sample wins over clear for its own channel
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < channels_p; i++) begin
      if (reset_i)                               state_q[i] <= '0;
      else if (load && int'(io.chan_i) == i)     state_q[i] <= acc;
      else if (io.clear_i)                       state_q[i] <= '0;
    end
  end
endmodule

// File: tb/tb_iir_multi.sv
// tb/tb_iir_multi.sv - directed self-checking bench for iir_multi
module tb_iir_multi;
  localparam int W  = 10;
  localparam int F  = 22;
  localparam int C  = 5;
  localparam int N  = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  iir_multi_if #(.width_p(W), .coef_frac_p(C), .channels_p(N)) bus ();

  iir_multi #(
    .width_p(W), .frac_p(F), .coef_frac_p(C), .channels_p(N)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dout();
    return int'(bus.data_o);
  endfunction

  task automatic send(input int ch, input int d, input int coef, input logic clr);
    bus.valid_i = 1'b1;
    bus.chan_i  = CW'(ch);
    bus.data_i  = W'(d);
    bus.coef_i  = (C+1)'(coef);
    bus.clear_i = clr;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int ch, input int val);
    check({tag, "_valid"}, int'(bus.valid_o), 1);
    check({tag, "_chan"}, int'(bus.chan_o), ch);
    check({tag, "_data"}, dout(), val);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.chan_i  = '0;
    bus.data_i  = '0;
    bus.coef_i  = '0;
    bus.clear_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_data", dout(), 0);
    check("rst_chan", int'(bus.chan_o), 0);
    check("rst_ready", int'(bus.ready_o), 1);
    rst = 1'b0;

    // unity and clamped coefficient
    send(0, 100, 32, 1'b0);  expect_out("unity_c0", 0, 100);
    check("tput_ready", int'(bus.ready_o), 1);
    send(1, 100, 63, 1'b0);  expect_out("clamp_c1", 1, 100);
    send(2, -100, 63, 1'b0); expect_out("clamp_c2", 2, -100);

    // half-coefficient step
    do_reset();
    send(0, 100, 16, 1'b0); expect_out("half1", 0, 50);
    send(0, 100, 16, 1'b0); expect_out("half2", 0, 75);
    send(0, 100, 16, 1'b0); expect_out("half3", 0, 87);
    send(0, 100, 16, 1'b0); expect_out("half4", 0, 93);
    send(0, 100, 16, 1'b0); expect_out("half5", 0, 96);

    // negative step
    do_reset();
    send(0, -100, 16, 1'b0); expect_out("neg1", 0, -50);
    send(0, -100, 16, 1'b0); expect_out("neg2", 0, -75);
    send(0, -100, 16, 1'b0); expect_out("neg3", 0, -88);

    // interleaved channels
    do_reset();
    send(0, 100, 16, 1'b0); expect_out("il0a", 0, 50);
    send(1, 200, 16, 1'b0); expect_out("il1a", 1, 100);
    send(0, 100, 16, 1'b0); expect_out("il0b", 0, 75);
    send(1, 200, 16, 1'b0); expect_out("il1b", 1, 150);
    send(0, 100, 16, 1'b0); expect_out("il0c", 0, 87);

    // backpressure: sample for ch1 held off for 5 cycles
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.chan_i  = CW'(1);
    bus.data_i  = W'(200);
    bus.coef_i  = (C+1)'(16);
    #1;
    check("bp_ready0", int'(bus.ready_o), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_ready", int'(bus.ready_o), 0);
      check("bp_data", dout(), 87);
      check("bp_chan", int'(bus.chan_o), 0);
    end
    bus.ready_i = 1'b1;
    send(1, 200, 16, 1'b0); expect_out("bp_rel1", 1, 175);
    send(1, 200, 16, 1'b0); expect_out("bp_rel2", 1, 187);

    // clear with coincident sample, then out-of-range channel
    do_reset();
    send(0, 100, 16, 1'b0); expect_out("cl_a", 0, 50);
    send(0, 100, 16, 1'b0); expect_out("cl_b", 0, 75);
    send(1, 100, 16, 1'b0); expect_out("cl_c", 1, 50);
    send(0, 100, 16, 1'b1); expect_out("cl_coin", 0, 50);
    send(1, 100, 16, 1'b0); expect_out("cl_other", 1, 50);
    send(0, 100, 16, 1'b0); expect_out("cl_kept", 0, 75);
    send(3, 100, 16, 1'b0);
    check("oor_valid", int'(bus.valid_o), 0);
    check("oor_ready", int'(bus.ready_o), 1);
    send(0, 100, 16, 1'b0); expect_out("oor_after", 0, 87);

    // reset while an output is pending
    do_reset();
    bus.ready_i = 1'b0;
    send(0, 100, 16, 1'b0); expect_out("mr_pend", 0, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mr_valid", int'(bus.valid_o), 0);
    check("mr_data", dout(), 0);
    bus.ready_i = 1'b1;
    send(0, 100, 16, 1'b0); expect_out("mr_restart", 0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
